// File: rtl/exec_unit_if.sv
// -----------------------------------------------------------------------------
// exec_unit_if
// Bundles the request side (start/op/operands/destination) and the register
// file write-back side (d_out/dr/ld) plus the status flags of exec_unit.
//
// Signals:
//   start  - request, sampled by exec_unit only while idle
//   op     - 3-bit opcode, sampled with start
//   a, b   - operands (register file OUTA/OUTB), sampled with start
//   dr_in  - destination register, sampled with start
//   busy   - high while an operation is in flight
//   d_out  - write data to register file D_in
//   dr     - write address to register file DR
//   ld     - one-cycle write strobe
//   z,n,c  - registered zero/negative/carry flags
//
// Modports:
//   master - the requester (drives request, observes results)
//   slave  - exec_unit itself
// -----------------------------------------------------------------------------
interface exec_unit_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [2:0]        op;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [ADDR_W-1:0] dr_in;
    logic              busy;
    logic [WIDTH-1:0]  d_out;
    logic [ADDR_W-1:0] dr;
    logic              ld;
    logic              z;
    logic              n;
    logic              c;

    modport master (
        output start, op, a, b, dr_in,
        input  busy, d_out, dr, ld, z, n, c
    );

    modport slave (
        input  start, op, a, b, dr_in,
        output busy, d_out, dr, ld, z, n, c
    );
endinterface

// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
// Multi-cycle execute/write-back stage behind the 8x8 register file. Takes the
// two read-port operands, performs one ALU operation (or an iterative
// shift-add multiply) and drives the register file write port with a single
// cycle ld pulse. Keeps a registered Z/N/C flag set, updated when the
// write-back state is left.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   reset_n  - asynchronous active-low reset, aborts any operation in flight
//   bus      - exec_unit_if.slave (start/op/a/b/dr_in in; busy/d_out/dr/ld/z/n/c out)
//
// Configuration macro:
//   EXEC_MUL_EN - when defined, opcode 3'b111 is an 8-cycle shift-add multiply
//                 (low WIDTH bits of a*b, c = high half non-zero). When not
//                 defined, opcode 3'b111 is MOV (result = b, c = 0) through the
//                 normal single-cycle execute path.
//
// States: IDLE -> EXEC -> WB -> IDLE, or IDLE -> MUL (x WIDTH) -> WB -> IDLE.
// -----------------------------------------------------------------------------
module exec_unit #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic      clk,
    input  logic      reset_n,
    exec_unit_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
`ifdef EXEC_MUL_EN
        MUL  = 2'd2,
`endif
        WB   = 2'd3
    } state_t;

    state_t            state_r;
    logic [2:0]        op_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic [ADDR_W-1:0] dr_lat_r;
    logic              cy_r;
    logic [WIDTH-1:0]  d_out_r;
    logic [ADDR_W-1:0] dr_r;
    logic              ld_r;
    logic              busy_r;
    logic              z_r;
    logic              n_r;
    logic              c_r;
    logic [WIDTH:0]    alu_s;

`ifdef EXEC_MUL_EN
    logic [2*WIDTH-1:0] acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [2*WIDTH-1:0] acc_next_s;
    logic               mul_done_s;
`endif

    // Single-cycle ALU. Returns {carry, result}. Shifts put the last bit
    // shifted out in the carry position, which is naturally 0 for a zero shift.
    function automatic logic [WIDTH:0] alu_f(
        input logic [2:0]       op_v,
        input logic [WIDTH-1:0] a_v,
        input logic [WIDTH-1:0] b_v
    );
        logic [WIDTH:0] r;
        logic [WIDTH:0] t;
        logic [2:0]     sh;
        sh = b_v[2:0];
        t  = {(WIDTH+1){1'b0}};
        case (op_v)
            3'b000: r = {1'b0, a_v} + {1'b0, b_v};
            3'b001: r = {1'b0, a_v} - {1'b0, b_v};   // bit WIDTH is the borrow
            3'b010: r = {1'b0, a_v & b_v};
            3'b011: r = {1'b0, a_v | b_v};
            3'b100: r = {1'b0, a_v ^ b_v};
            3'b101: r = {1'b0, a_v} << sh;
            3'b110: begin
                // Extra LSB catches the last bit shifted out to the right.
                t = {a_v, 1'b0} >> sh;
                r = {t[0], t[WIDTH:1]};
            end
            3'b111: r = {1'b0, b_v};                  // MOV (multiply uses MUL state)
            default: r = {(WIDTH+1){1'b0}};
        endcase
        return r;
    endfunction

    // ALU result for the latched operation.
    always_comb begin
        alu_s = alu_f(op_r, a_r, b_r);
    end

`ifdef EXEC_MUL_EN
    // One shift-add step: add a << cnt when multiplier bit cnt is set.
    always_comb begin
        acc_next_s = acc_r;
        if (b_r[cnt_r]) begin
            acc_next_s = acc_r + ({{WIDTH{1'b0}}, a_r} << cnt_r);
        end else begin
            acc_next_s = acc_r;
        end
        mul_done_s = (cnt_r == CNT_W'(WIDTH - 1));
    end
`endif

    // Control FSM with registered outputs and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            op_r     <= 3'b000;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            dr_lat_r <= {ADDR_W{1'b0}};
            cy_r     <= 1'b0;
            d_out_r  <= {WIDTH{1'b0}};
            dr_r     <= {ADDR_W{1'b0}};
            ld_r     <= 1'b0;
            busy_r   <= 1'b0;
            z_r      <= 1'b0;
            n_r      <= 1'b0;
            c_r      <= 1'b0;
`ifdef EXEC_MUL_EN
            acc_r    <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    ld_r <= 1'b0;
                    if (bus.start) begin
                        op_r     <= bus.op;
                        a_r      <= bus.a;
                        b_r      <= bus.b;
                        dr_lat_r <= bus.dr_in;
                        busy_r   <= 1'b1;
`ifdef EXEC_MUL_EN
                        if (bus.op == 3'b111) begin
                            state_r <= MUL;
                            acc_r   <= {(2*WIDTH){1'b0}};
                            cnt_r   <= {CNT_W{1'b0}};
                        end else begin
                            state_r <= EXEC;
                        end
`else
                        state_r  <= EXEC;
`endif
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                EXEC: begin
                    cy_r    <= alu_s[WIDTH];
                    d_out_r <= alu_s[WIDTH-1:0];
                    dr_r    <= dr_lat_r;
                    ld_r    <= 1'b1;
                    state_r <= WB;
                end
`ifdef EXEC_MUL_EN
                MUL: begin
                    acc_r <= acc_next_s;
                    if (mul_done_s) begin
                        cy_r    <= |acc_next_s[2*WIDTH-1:WIDTH];
                        d_out_r <= acc_next_s[WIDTH-1:0];
                        dr_r    <= dr_lat_r;
                        ld_r    <= 1'b1;
                        state_r <= WB;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
`endif
                WB: begin
                    // Flags follow the written result, visible after ld.
                    ld_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    z_r     <= (d_out_r == {WIDTH{1'b0}});
                    n_r     <= d_out_r[WIDTH-1];
                    c_r     <= cy_r;
                    state_r <= IDLE;
                end
                default: begin
                    ld_r    <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_r;
    assign bus.d_out = d_out_r;
    assign bus.dr    = dr_r;
    assign bus.ld    = ld_r;
    assign bus.z     = z_r;
    assign bus.n     = n_r;
    assign bus.c     = c_r;

endmodule

// File: tb/tb_exec_unit.sv
// -----------------------------------------------------------------------------
// tb_exec_unit
// Directed self-checking bench for exec_unit. Expected write-backs are pushed
// to a scoreboard queue when an operation is started and popped when ld is
// seen. Honors EXEC_MUL_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_exec_unit;

    typedef struct {
        logic [7:0] d;
        logic [2:0] dr;
        logic       c;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_total;
    exp_t sb[$];

    exec_unit_if #(.WIDTH(8), .ADDR_W(3)) bus ();

    exec_unit #(.WIDTH(8), .ADDR_W(3)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour, written directly from the opcode table.
    function automatic exp_t model(input logic [2:0] op_v, input logic [7:0] a_v,
                                   input logic [7:0] b_v, input logic [2:0] dr_v);
        exp_t        e;
        int unsigned sh;
        int unsigned p;
        sh   = b_v[2:0];
        e.dr = dr_v;
        e.c  = 1'b0;
        case (op_v)
            3'd0: begin p = a_v + b_v; e.d = p[7:0]; e.c = (p > 255); end
            3'd1: begin e.d = a_v - b_v; e.c = (a_v < b_v); end
            3'd2: e.d = a_v & b_v;
            3'd3: e.d = a_v | b_v;
            3'd4: e.d = a_v ^ b_v;
            3'd5: begin e.d = a_v << sh; e.c = (sh == 0) ? 1'b0 : a_v[8 - sh]; end
            3'd6: begin e.d = a_v >> sh; e.c = (sh == 0) ? 1'b0 : a_v[sh - 1]; end
            default: begin
                if (MUL_EN) begin
                    p = a_v * b_v; e.d = p[7:0]; e.c = (p > 255);
                end else begin
                    e.d = b_v; e.c = 1'b0;
                end
            end
        endcase
        return e;
    endfunction

    function automatic int latency(input logic [2:0] op_v);
        return (MUL_EN && op_v == 3'd7) ? 8 : 1;
    endfunction

    // Start one op, scramble operands afterwards, and check the write-back,
    // its timing, and the flags on the following cycle.
    task automatic run_op(input string tag, input logic [2:0] op_v, input logic [7:0] a_v,
                          input logic [7:0] b_v, input logic [2:0] dr_v);
        exp_t e;
        bit   found;
        int   lat;
        lat = latency(op_v);
        sb.push_back(model(op_v, a_v, b_v, dr_v));
        @(posedge clk); #1;
        bus.op = op_v; bus.a = a_v; bus.b = b_v; bus.dr_in = dr_v; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a = 8'($urandom); bus.b = 8'($urandom);
        bus.op = 3'($urandom); bus.dr_in = 3'($urandom);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        found = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (bus.ld) begin
                found = 1'b1;
                chk({tag, "_lat"}, k, lat);
                e = sb.pop_front();
                chk({tag, "_d"}, 32'(bus.d_out), 32'(e.d));
                chk({tag, "_dr"}, 32'(bus.dr), 32'(e.dr));
                @(posedge clk); #1;
                chk({tag, "_ld_width"}, 32'(bus.ld), 32'd0);
                chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
                chk({tag, "_d_hold"}, 32'(bus.d_out), 32'(e.d));
                chk({tag, "_z"}, 32'(bus.z), 32'(e.d == 8'h00));
                chk({tag, "_n"}, 32'(bus.n), 32'(e.d[7]));
                chk({tag, "_c"}, 32'(bus.c), 32'(e.c));
                break;
            end
        end
        if (!found) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        int   ld_cnt;
        int   first_k;
        int   low_k;
        int   lat;
        n_pass  = 0;
        n_total = 0;
        reset_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.a = 8'h00; bus.b = 8'h00; bus.dr_in = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ld", 32'(bus.ld), 32'd0);
        chk("rst_d", 32'(bus.d_out), 32'd0);
        chk("rst_dr", 32'(bus.dr), 32'd0);
        chk("rst_flags", 32'({bus.z, bus.n, bus.c}), 32'd0);
        reset_n = 1'b1;

        run_op("add", 3'd0, 8'hF0, 8'h20, 3'd5);
        run_op("sub_eq", 3'd1, 8'h05, 8'h05, 3'd1);
        run_op("sub_neg", 3'd1, 8'h03, 8'h05, 3'd2);
        run_op("mul", 3'd7, 8'h10, 8'h11, 3'd3);
        run_op("shl0", 3'd5, 8'h81, 8'h00, 3'd4);
        run_op("shl1", 3'd5, 8'h81, 8'h01, 3'd4);
        run_op("shr1", 3'd6, 8'h81, 8'h01, 3'd6);
        run_op("shr7", 3'd6, 8'h80, 8'hFF, 3'd7);
        run_op("and", 3'd2, 8'hCC, 8'hAA, 3'd0);
        run_op("or", 3'd3, 8'h0C, 8'hA0, 3'd1);
        run_op("xor", 3'd4, 8'hFF, 8'hFF, 3'd2);
        run_op("mul_big", 3'd7, 8'hFF, 8'hFF, 3'd5);

        // START pulses while busy must be ignored.
        lat = latency(3'd7);
        sb.push_back(model(3'd7, 8'h0B, 8'h0D, 3'd6));
        @(posedge clk); #1;
        bus.op = 3'd7; bus.a = 8'h0B; bus.b = 8'h0D; bus.dr_in = 3'd6; bus.start = 1'b1;
        @(posedge clk); #1;
        ld_cnt = 0; first_k = 0; low_k = 0;
        for (int k = 1; k <= 14; k++) begin
            bus.start = bus.busy;
            bus.op = 3'd0; bus.dr_in = 3'd1; bus.a = 8'($urandom); bus.b = 8'($urandom);
            @(posedge clk); #1;
            if (bus.ld) begin
                ld_cnt++;
                if (ld_cnt == 1) begin
                    first_k = k;
                    e = sb.pop_front();
                    chk("ign_d", 32'(bus.d_out), 32'(e.d));
                    chk("ign_dr", 32'(bus.dr), 32'(e.dr));
                end
            end
            if (!bus.busy && low_k == 0) low_k = k;
        end
        bus.start = 1'b0;
        sb.delete();
        chk("ign_ld_count", ld_cnt, 1);
        chk("ign_ld_cycle", first_k, lat);
        chk("ign_busy_low", low_k, lat + 1);

        // Mid-operation reset: flags are non-zero beforehand.
        run_op("pre_rst", 3'd1, 8'h03, 8'h05, 3'd2);
        @(posedge clk); #1;
        bus.op = 3'd7; bus.a = 8'h10; bus.b = 8'h11; bus.dr_in = 3'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (MUL_EN) begin
            repeat (3) @(posedge clk);
            #1;
        end
        reset_n = 1'b0;
        #1;
        chk("ar_busy", 32'(bus.busy), 32'd0);
        chk("ar_ld", 32'(bus.ld), 32'd0);
        chk("ar_flags", 32'({bus.z, bus.n, bus.c}), 32'd0);
        chk("ar_d", 32'(bus.d_out), 32'd0);
        #3;
        reset_n = 1'b1;
        ld_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.ld) ld_cnt++;
        end
        chk("ar_no_ld", ld_cnt, 0);
        chk("ar_idle", 32'(bus.busy), 32'd0);
        run_op("post_rst_add", 3'd0, 8'h12, 8'h34, 3'd7);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
